// File: rtl/scan_pkg.sv
// Shared scan-sequencer types: channel geometry and FSM state encoding.
// Pure declarations, no logic; imported by the finder and the sequencer.
package scan_pkg;

   localparam int NCHAN  = 8;
   localparam int CHAN_W = 3;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_DWELL_ENC = 2'd1;
   localparam logic [1:0] ST_DONE_ENC  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE_ENC,
      DWELL = ST_DWELL_ENC,
      DONE  = ST_DONE_ENC
   } state_t;

endpackage

// File: rtl/next_chan_find.sv
// Finds the nearest enabled channel above the current one, plus the lowest enabled channel.
// Purely combinational (zero latency); no flow control.
module next_chan_find
   import scan_pkg::*;
(
   input  logic [NCHAN-1:0]  mask_i,
   input  logic [CHAN_W-1:0] cur_i,
   output logic              found_o,
   output logic [CHAN_W-1:0] next_o,
   output logic [CHAN_W-1:0] low_o
);

   // Descending walk so the last hit is the closest one to the bottom / to cur_i.
   always_comb begin
      found_o = 1'b0;
      next_o  = '0;
      low_o   = '0;
      for (int k = NCHAN - 1; k >= 0; k--) begin
         if (mask_i[k]) begin
            low_o = CHAN_W'(k);
            if (k > int'(cur_i)) begin
               found_o = 1'b1;
               next_o  = CHAN_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/channel_scan_seq.sv
// Steps a 3-to-8 decoder through the masked channels, holding each for dwell+1 cycles.
// Registered outputs, index/en valid one cycle after start; stop and rst abort without pulses.
module channel_scan_seq
   import scan_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [NCHAN-1:0]   mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic               i0,
   output logic               i1,
   output logic               i2,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   state_t              state_q, state_d;
   logic [CHAN_W-1:0]   idx_q, idx_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic [NCHAN-1:0]    mask_q, mask_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic                en_q, en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wrap_q, wrap_d;

   logic [NCHAN-1:0]    search_mask;
   logic                found;
   logic [CHAN_W-1:0]   next_idx;
   logic [CHAN_W-1:0]   low_idx;

   // In IDLE the finder looks at the live mask so the first channel is ready at the start edge.
   assign search_mask = (state_q == IDLE) ? mask : mask_q;

   next_chan_find u_find (
      .mask_i  (search_mask),
      .cur_i   (idx_q),
      .found_o (found),
      .next_o  (next_idx),
      .low_o   (low_idx)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      wrap_d  = 1'b0;
      if (stop) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (mask != '0)) begin
                  mask_d  = mask;
                  dwell_d = dwell;
                  idx_d   = low_idx;
                  cnt_d   = dwell;
                  state_d = DWELL;
               end
            end
            DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end else if (found) begin
                  idx_d = next_idx;
                  cnt_d = dwell_q;
               end else if (continuous) begin
                  idx_d  = low_idx;
                  cnt_d  = dwell_q;
                  wrap_d = 1'b1;
               end else begin
                  idx_d   = '0;
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
      en_d   = (state_d == DWELL);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         dwell_q <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         dwell_q <= dwell_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign i0   = idx_q[0];
   assign i1   = idx_q[1];
   assign i2   = idx_q[2];
   assign en   = en_q;
   assign busy = busy_q;
   assign done = done_q;
   assign wrap = wrap_q;

endmodule

// File: doc/channel_scan_seq.md
CHANNEL_SCAN_SEQ -- requirements
Module: channel_scan_seq

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, giving the dwell counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; one clock, reset asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin a scan.
REQ-005 The block SHALL have port stop, input, 1, to abort a scan.
REQ-006 The block SHALL have port continuous, input, 1: 1 = wrap and repeat, 0 = single pass.
REQ-007 The block SHALL have port mask, input, 8, where bit k = 1 includes channel k.
REQ-008 The block SHALL have port dwell, input, DWELL_W; each channel is held for dwell+1 cycles.
REQ-009 The block SHALL have ports i0, i1, i2, output, 1 each, carrying the current channel index (i0 = LSB), for the 3-to-8 decoder select inputs.
REQ-010 The block SHALL have port en, output, 1, the decoder enable, high only while a channel is being driven.
REQ-011 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse at completion of a single pass.
REQ-013 The block SHALL have port wrap, output, 1, a one-cycle pulse when a continuous scan returns to its lowest channel.

Function
REQ-014 The block SHALL implement states IDLE, DWELL and DONE; all outputs SHALL be registered.
REQ-015 In IDLE with start=1, stop=0 and mask≠0, the block SHALL latch mask and dwell, load the lowest set mask bit as the index, load the counter with dwell, and enter DWELL.
REQ-016 en and the index SHALL be valid on the cycle after the start edge (latency 1).
REQ-017 In IDLE, start with mask=0 SHALL be ignored: no state change and no pulse.
REQ-018 In DWELL, en SHALL be 1, and the counter SHALL decrement each cycle until it reaches 0.
REQ-019 In DWELL with counter=0, if a latched mask bit above the current index exists, the index SHALL move to the nearest such bit, the counter SHALL reload, and en SHALL stay 1 (no gap cycle).
REQ-020 In DWELL with counter=0 and no higher bit set, continuous=1 SHALL reload the lowest set bit, reload the counter, and pulse wrap for one cycle, concurrent with the new index.
REQ-021 In the same condition, continuous=0 SHALL enter DONE, with en=0 and done=1 for one cycle, then IDLE.
REQ-022 The continuous input SHALL be sampled live; mask and dwell SHALL be used only as latched at start.
REQ-023 With a single latched channel and continuous=1, the index SHALL stay constant, and wrap SHALL pulse every dwell+1 cycles.
REQ-024 stop=1 in any state SHALL force IDLE on the next edge, with en=0, index 0, and no done or wrap pulse.
REQ-025 When start and stop are high together, stop SHALL win.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 The index SHALL be 0 whenever en=0.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and set i0, i1, i2, en, busy, done and wrap to 0, the counter to 0 and the latched mask to 0.
REQ-029 Reset SHALL abort a scan mid-operation without any done or wrap pulse.
REQ-030 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-031 The shared package scan_pkg SHALL hold the state encoding localparams, NCHAN=8 and CHAN_W=3.
REQ-032 The next-enabled-channel search (mask, current index → found flag, next index, lowest index) SHALL be a combinational sub-module named next_chan_find.
REQ-033 The top level SHALL contain only the FSM, the counter and the output registers.

Verification
REQ-034 Single pass: mask=8'b1010_0101, dwell=1, continuous=0, start → index 0,0,2,2,5,5,7,7 with en=1, then done=1 for one cycle and en=0.
REQ-035 Continuous: mask=8'h81, dwell=0 → index 0,7,0,7…; wrap=1 on each return to 0; busy stays 1.
REQ-036 Stop mid-scan: mask=8'hFF, dwell=3, stop on the 6th cycle of the scan → next cycle en=0, busy=0, index 0, no done pulse.
REQ-037 Edge cases: start with mask=0 → no activity. start and stop together → stays IDLE. start while busy → sequence unchanged.
REQ-038 Latching: change mask and dwell mid-scan → sequence follows the values latched at start.
REQ-039 Async reset: assert rst between clock edges during DWELL → outputs 0 immediately; a restart after release runs from the lowest channel.
